dmem_bridge: RTL and testbench

// - MEM-stage data-memory bridge, one hop downstream of the load/store byte selector.
// - Converts the selector's per-access request (sel, size, addr, aligned wdata) into an SRAM-like
//   req/addr_ok/data_ok transaction.
// - Stalls the pipeline while the access is in flight and holds the returned word as the

---
 rtl/dmem_bridge.sv | 148 ++++++++++++++
 tb/tb_dmem_bridge.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bridge.sv
// MEM-stage bridge from the load/store byte selector to an SRAM-like req/addr_ok/data_ok data port.
// Define DMEM_ADDR_CHECK_EN to trap misaligned half/word accesses instead of issuing them.
module dmem_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_en,
    input  logic                mem_wen,
    input  logic [DATA_W/8-1:0] sel,
    input  logic [1:0]          size,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                ext_stall,
    input  logic                flush,
    output logic                stall_mem,
    output logic [DATA_W-1:0]   rdata_out,
    output logic                data_req,
    output logic                data_wr,
    output logic [1:0]          data_size,
    output logic [ADDR_W-1:0]   data_addr,
    output logic [DATA_W/8-1:0] data_wstrb,
    output logic [DATA_W-1:0]   data_wdata,
    input  logic                data_addr_ok,
    input  logic                data_data_ok,
    input  logic [DATA_W-1:0]   data_rdata,
    output logic                addr_err_load,
    output logic                addr_err_store
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t state, state_nx;
    logic   cancel;
    logic   start;
    logic   capture;
    logic   stall_c;

`ifdef DMEM_ADDR_CHECK_EN
    logic bad_align;
    logic err_ld;
    logic err_st;

    always_comb begin
        bad_align = 1'b0;
        if (size == 2'b01)
            bad_align = addr[0];
        else if (size == 2'b10)
            bad_align = (addr[1:0] != 2'b00);
    end

    assign addr_err_load  = err_ld & ~rst;
    assign addr_err_store = err_st & ~rst;
`else
    assign addr_err_load  = 1'b0;
    assign addr_err_store = 1'b0;
`endif

    // Once flushed, the bridge only holds the pipeline for a new memory
    // instruction that must wait for the orphaned transaction to drain.
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        capture  = 1'b0;
        stall_c  = 1'b0;
`ifdef DMEM_ADDR_CHECK_EN
        err_ld   = 1'b0;
        err_st   = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (mem_en && !flush) begin
`ifdef DMEM_ADDR_CHECK_EN
                    if (bad_align) begin
                        err_ld = ~mem_wen;
                        err_st = mem_wen;
                    end else
`endif
                    begin
                        start    = 1'b1;
                        stall_c  = 1'b1;
                        state_nx = S_REQ;
                    end
                end
            end
            S_REQ: begin
                stall_c = !flush && (cancel ? mem_en : 1'b1);
                if (data_addr_ok)
                    state_nx = S_WAIT;
            end
            S_WAIT: begin
                stall_c = !flush && (cancel ? mem_en : 1'b1);
                if (data_data_ok) begin
                    if (cancel || flush) begin
                        state_nx = S_IDLE;
                    end else begin
                        state_nx = S_DONE;
                        capture  = ~data_wr;
                    end
                end
            end
            S_DONE: begin
                if (flush || !ext_stall)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign stall_mem = stall_c & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cancel     <= 1'b0;
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_size  <= '0;
            data_addr  <= '0;
            data_wstrb <= '0;
            data_wdata <= '0;
            rdata_out  <= '0;
        end else begin
            state <= state_nx;

            if (state_nx == S_IDLE)
                cancel <= 1'b0;
            else if (flush && (state == S_REQ || state == S_WAIT))
                cancel <= 1'b1;

            if (start) begin
                data_req   <= 1'b1;
                data_wr    <= mem_wen;
                data_size  <= size;
                data_addr  <= addr;
                data_wstrb <= mem_wen ? sel : '0;
                data_wdata <= wdata;
            end else if (state == S_REQ && data_addr_ok) begin
                data_req <= 1'b0;
            end

            if (capture)
                rdata_out <= data_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed, table-driven bench for dmem_bridge: one row per clock cycle of stimulus
// with the outputs expected in that cycle, plus hand sequences for reset and alignment traps.
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en, mem_wen, ext_stall, flush;
    logic [3:0]  sel;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        stall_mem;
    logic [31:0] rdata_out;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic        addr_err_load, addr_err_store;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wen(mem_wen), .sel(sel), .size(size),
        .addr(addr), .wdata(wdata), .ext_stall(ext_stall), .flush(flush),
        .stall_mem(stall_mem), .rdata_out(rdata_out), .data_req(data_req), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr), .data_wstrb(data_wstrb),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .addr_err_load(addr_err_load), .addr_err_store(addr_err_store)
    );

    typedef struct {
        logic        men, wen;
        logic [3:0]  sel;
        logic [1:0]  sz;
        logic [31:0] a, wd;
        logic        xs, fl, aok, dok;
        logic [31:0] rd;
        logic        es, ereq;
        logic [31:0] erd;
        logic        ewr;
        logic [1:0]  esz;
        logic [31:0] ea;
        logic [3:0]  est;
        logic [31:0] ewd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(
        input logic men, input logic wen, input logic [3:0] s, input logic [1:0] sz,
        input logic [31:0] a, input logic [31:0] wd, input logic xs, input logic fl,
        input logic aok, input logic dok, input logic [31:0] rd,
        input logic es, input logic ereq, input logic [31:0] erd,
        input logic ewr, input logic [1:0] esz, input logic [31:0] ea,
        input logic [3:0] est, input logic [31:0] ewd);
        vec_t r;
        r.men = men; r.wen = wen; r.sel = s; r.sz = sz; r.a = a; r.wd = wd;
        r.xs = xs; r.fl = fl; r.aok = aok; r.dok = dok; r.rd = rd;
        r.es = es; r.ereq = ereq; r.erd = erd;
        r.ewr = ewr; r.esz = esz; r.ea = ea; r.est = est; r.ewd = ewd;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_en = 0; mem_wen = 0; sel = '0; size = '0; addr = '0; wdata = '0;
        ext_stall = 0; flush = 0; data_addr_ok = 0; data_data_ok = 0; data_rdata = '0;
    endtask

    initial begin
        // word load 0x100, zero-wait slave
        vecs.push_back(v(1,0,0,2,'h100,0, 0,0,0,0,0,          1,0,0,          0,0,0,0,0));
        vecs.push_back(v(1,0,0,2,'h100,0, 0,0,1,0,0,          1,1,0,          0,2,'h100,0,0));
        vecs.push_back(v(1,0,0,2,'h100,0, 0,0,0,1,'hDEADBEEF, 1,0,0,          0,0,0,0,0));
        vecs.push_back(v(1,0,0,2,'h100,0, 0,0,0,0,0,          0,0,'hDEADBEEF, 0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,     0,0,0,0,0,          0,0,'hDEADBEEF, 0,0,0,0,0));
        // byte store 0x102, data_ok rdata must be ignored
        vecs.push_back(v(1,1,4,0,'h102,'h5A5A5A5A, 0,0,0,0,0,          1,0,'hDEADBEEF, 0,0,0,0,0));
        vecs.push_back(v(1,1,4,0,'h102,'h5A5A5A5A, 0,0,1,0,0,          1,1,'hDEADBEEF, 1,0,'h102,4,'h5A5A5A5A));
        vecs.push_back(v(1,1,4,0,'h102,'h5A5A5A5A, 0,0,0,1,'hFFFFFFFF, 1,0,'hDEADBEEF, 0,0,0,0,0));
        vecs.push_back(v(1,1,4,0,'h102,'h5A5A5A5A, 0,0,0,0,0,          0,0,'hDEADBEEF, 0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,              0,0,0,0,0,          0,0,'hDEADBEEF, 0,0,0,0,0));
        // backpressure: addr_ok withheld 4 cycles, inputs wander, stray data_ok in REQ
        vecs.push_back(v(1,0,0,2,'h200,0,    0,0,0,0,0,          1,0,'hDEADBEEF, 0,0,0,0,0));
        vecs.push_back(v(1,1,4,0,'h3FC,'h77, 0,0,0,1,'hBAD,      1,1,'hDEADBEEF, 0,2,'h200,0,0));
        vecs.push_back(v(1,1,4,0,'h3FC,'h77, 0,0,0,0,0,          1,1,'hDEADBEEF, 0,2,'h200,0,0));
        vecs.push_back(v(1,1,4,0,'h3FC,'h77, 0,0,0,0,0,          1,1,'hDEADBEEF, 0,2,'h200,0,0));
        vecs.push_back(v(1,1,4,0,'h3FC,'h77, 0,0,0,0,0,          1,1,'hDEADBEEF, 0,2,'h200,0,0));
        vecs.push_back(v(1,0,0,2,'h200,0,    0,0,1,0,0,          1,1,'hDEADBEEF, 0,2,'h200,0,0));
        vecs.push_back(v(1,0,0,2,'h200,0,    0,0,0,0,0,          1,0,'hDEADBEEF, 0,0,0,0,0));
        vecs.push_back(v(1,0,0,2,'h200,0,    0,0,0,1,'hCAFEF00D, 1,0,'hDEADBEEF, 0,0,0,0,0));
        vecs.push_back(v(1,0,0,2,'h200,0,    0,0,0,0,0,          0,0,'hCAFEF00D, 0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,        0,0,0,0,0,          0,0,'hCAFEF00D, 0,0,0,0,0));
        // flush in WAIT: data discarded, back to IDLE, no second request
        vecs.push_back(v(1,0,0,2,'h40,0, 0,0,0,0,0,          1,0,'hCAFEF00D, 0,0,0,0,0));
        vecs.push_back(v(1,0,0,2,'h40,0, 0,0,1,0,0,          1,1,'hCAFEF00D, 0,2,'h40,0,0));
        vecs.push_back(v(1,0,0,2,'h40,0, 0,1,0,0,0,          0,0,'hCAFEF00D, 0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,    0,0,0,1,'h12345678, 0,0,'hCAFEF00D, 0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,    0,0,0,0,0,          0,0,'hCAFEF00D, 0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,    0,0,0,0,0,          0,0,'hCAFEF00D, 0,0,0,0,0));
        // ext_stall held 2 cycles in DONE with mem_en high, then next access
        vecs.push_back(v(1,0,0,2,'h80,0, 0,0,0,0,0,          1,0,'hCAFEF00D, 0,0,0,0,0));
        vecs.push_back(v(1,0,0,2,'h80,0, 0,0,1,0,0,          1,1,'hCAFEF00D, 0,2,'h80,0,0));
        vecs.push_back(v(1,0,0,2,'h80,0, 0,0,0,1,'h11223344, 1,0,'hCAFEF00D, 0,0,0,0,0));
        vecs.push_back(v(1,0,0,2,'h80,0, 1,0,0,0,0,          0,0,'h11223344, 0,0,0,0,0));
        vecs.push_back(v(1,0,0,2,'h80,0, 1,0,0,0,0,          0,0,'h11223344, 0,0,0,0,0));
        vecs.push_back(v(1,0,0,2,'h80,0, 0,0,0,0,0,          0,0,'h11223344, 0,0,0,0,0));
        vecs.push_back(v(1,0,0,2,'h84,0, 0,0,0,0,0,          1,0,'h11223344, 0,0,0,0,0));
        vecs.push_back(v(1,0,0,2,'h84,0, 0,0,1,0,0,          1,1,'h11223344, 0,2,'h84,0,0));
        vecs.push_back(v(1,0,0,2,'h84,0, 0,0,0,1,'h55667788, 1,0,'h11223344, 0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,    0,0,0,0,0,          0,0,'h55667788, 0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,    0,0,0,0,0,          0,0,'h55667788, 0,0,0,0,0));
        // flush together with mem_en in IDLE: nothing issued
        vecs.push_back(v(1,0,0,2,'h500,0, 0,1,0,0,0,         0,0,'h55667788, 0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,     0,0,0,0,0,         0,0,'h55667788, 0,0,0,0,0));
        // flush in REQ: request held until accepted, new load waits behind it
        vecs.push_back(v(1,0,0,2,'h10,0, 0,0,0,0,0,          1,0,'h55667788, 0,0,0,0,0));
        vecs.push_back(v(1,0,0,2,'h10,0, 0,1,0,0,0,          0,1,'h55667788, 0,2,'h10,0,0));
        vecs.push_back(v(1,0,0,2,'h20,0, 0,0,1,0,0,          1,1,'h55667788, 0,2,'h10,0,0));
        vecs.push_back(v(1,0,0,2,'h20,0, 0,0,0,1,'hAAAAAAAA, 1,0,'h55667788, 0,0,0,0,0));
        vecs.push_back(v(1,0,0,2,'h20,0, 0,0,0,0,0,          1,0,'h55667788, 0,0,0,0,0));
        vecs.push_back(v(1,0,0,2,'h20,0, 0,0,1,0,0,          1,1,'h55667788, 0,2,'h20,0,0));
        vecs.push_back(v(1,0,0,2,'h20,0, 0,0,0,1,'h00000099, 1,0,'h55667788, 0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,    0,0,0,0,0,          0,0,'h00000099, 0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,    0,0,0,0,0,          0,0,'h00000099, 0,0,0,0,0));

        // reset with a pending load presented: stall gated, registers cleared
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        mem_en = 1; size = 2; addr = 'h100;
        #2;
        chk("reset stall_mem", {31'd0, stall_mem}, 0);
        @(negedge clk);
        #2;
        chk("reset data_req", {31'd0, data_req}, 0);
        chk("reset rdata_out", rdata_out, 0);
        chk("reset data_addr", data_addr, 0);
        chk("reset errors", {30'd0, addr_err_load, addr_err_store}, 0);
        rst = 1'b0;
        idle_inputs();

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            mem_en = vecs[i].men; mem_wen = vecs[i].wen; sel = vecs[i].sel; size = vecs[i].sz;
            addr = vecs[i].a; wdata = vecs[i].wd; ext_stall = vecs[i].xs; flush = vecs[i].fl;
            data_addr_ok = vecs[i].aok; data_data_ok = vecs[i].dok; data_rdata = vecs[i].rd;
            #2;
            chk($sformatf("row%0d stall_mem", i), {31'd0, stall_mem}, {31'd0, vecs[i].es});
            chk($sformatf("row%0d data_req", i), {31'd0, data_req}, {31'd0, vecs[i].ereq});
            chk($sformatf("row%0d rdata_out", i), rdata_out, vecs[i].erd);
            chk($sformatf("row%0d errors", i), {30'd0, addr_err_load, addr_err_store}, 0);
            if (vecs[i].ereq) begin
                chk($sformatf("row%0d data_wr", i), {31'd0, data_wr}, {31'd0, vecs[i].ewr});
                chk($sformatf("row%0d data_size", i), {30'd0, data_size}, {30'd0, vecs[i].esz});
                chk($sformatf("row%0d data_addr", i), data_addr, vecs[i].ea);
                chk($sformatf("row%0d data_wstrb", i), {28'd0, data_wstrb}, {28'd0, vecs[i].est});
                chk($sformatf("row%0d data_wdata", i), data_wdata, vecs[i].ewd);
            end
        end

        // synchronous reset while a request is outstanding
        @(negedge clk);
        idle_inputs();
        mem_en = 1; size = 2; addr = 'h30;
        @(negedge clk);
        idle_inputs();
        #2;
        chk("midrst req before", {31'd0, data_req}, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("midrst data_req", {31'd0, data_req}, 0);
        chk("midrst stall_mem", {31'd0, stall_mem}, 0);
        chk("midrst rdata_out", rdata_out, 0);
        @(negedge clk);
        #2;
        chk("midrst stays idle", {31'd0, data_req}, 0);

`ifdef DMEM_ADDR_CHECK_EN
        // misaligned word load traps in IDLE without a request
        @(negedge clk);
        idle_inputs();
        mem_en = 1; size = 2; addr = 'h102;
        #2;
        chk("misalign err_load", {31'd0, addr_err_load}, 1);
        chk("misalign err_store", {31'd0, addr_err_store}, 0);
        chk("misalign stall_mem", {31'd0, stall_mem}, 0);
        @(negedge clk);
        idle_inputs();
        #2;
        chk("misalign err pulse", {31'd0, addr_err_load}, 0);
        chk("misalign no req", {31'd0, data_req}, 0);
        @(negedge clk);
        #2;
        chk("misalign no req later", {31'd0, data_req}, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
